// File: rtl/pwm_dac_driver_pkg.sv
// Shared types and default sizing for the PWM DAC driver slice.
package sound_pkg;

  localparam int N_DEF   = 7;
  localparam int DIV_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } DAC_STATE;

endpackage

// File: rtl/pwm_dac_driver_if.sv
// Sample stream handshake between the sound generator and the PWM DAC driver.
interface pwm_dac_driver_if
  import sound_pkg::*;
#(
  parameter int N = N_DEF
);

  logic [N-1:0] dacCount;
  logic         sample_valid;
  logic         sample_ready;

  modport master (output dacCount, output sample_valid, input sample_ready);
  modport slave  (input dacCount, input sample_valid, output sample_ready);

endinterface

// File: rtl/pwm_dac_driver_tick_prescaler.sv
// Divides the clock into PWM ticks; the divider is parked at zero while not running.
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] prescale_q, prescale_d;

  // With DIV=1, LAST is zero so the counter never leaves zero and tick follows run.
  always_comb begin
    prescale_d = prescale_q;
    if (!run || (prescale_q == LAST)) begin
      prescale_d = '0;
    end else begin
      prescale_d = prescale_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  assign tick = run && (prescale_q == LAST);

endmodule

// File: rtl/pwm_dac_driver.sv
// PWM DAC driver: one-entry shadow buffer feeding a duty register that reloads only at period boundaries.
module pwm_dac_driver
  import sound_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  pwm_dac_driver_if.slave     smp,
  output logic                pwm_o,
  output logic                period_start_o,
  output logic                underrun_o
);

  localparam logic [N-1:0] CNT_MAX = '1;

  DAC_STATE     state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] duty_q, duty_d;
  logic [N-1:0] shadow_q, shadow_d;
  logic         shadow_full_q, shadow_full_d;
  logic         period_start_q, period_start_d;
  logic         underrun_q, underrun_d;

  logic tick;
  logic wrap;
  logic load;
  logic accept;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (state_q != IDLE),
    .tick (tick)
  );

  assign wrap   = tick && (cnt_q == CNT_MAX);
  assign accept = smp.sample_valid && !shadow_full_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    duty_d        = duty_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if (wrap) load = 1'b1;
        if (!enable_i) state_d = FLUSH;
      end
      FLUSH: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        // Re-enable before the final wrap resumes the same waveform; that wrap becomes a normal load.
        if (enable_i) begin
          state_d = RUN;
          load    = wrap;
        end else if (wrap) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Load only ever clears a full shadow and accept only fills an empty one, so they cannot collide.
    if (load && shadow_full_q) begin
      duty_d        = shadow_q;
      shadow_full_d = 1'b0;
    end
    if (accept) begin
      shadow_d      = smp.dacCount;
      shadow_full_d = 1'b1;
    end

    period_start_d = load;
    underrun_d     = load && !shadow_full_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      duty_q         <= '0;
      shadow_q       <= '0;
      shadow_full_q  <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      shadow_q       <= shadow_d;
      shadow_full_q  <= shadow_full_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign smp.sample_ready = !shadow_full_q;
  assign pwm_o            = (state_q != IDLE) && (cnt_q < duty_q);
  assign period_start_o   = period_start_q;
  assign underrun_o       = underrun_q;

endmodule

// File: doc/pwm_dac_driver.md
Name: pwm_dac_driver

Overview:
Consumes the N-bit sample stream produced by the sound generator (the dacCount value) and converts it into a single-bit PWM waveform for the speaker pin. It owns a one-entry shadow buffer with a valid/ready handshake and a free-running period counter. Duty updates are glitch-free: a new duty value takes effect only at a period boundary. It sits between the sound generator and the top-level audio output pad.

Parameters:
N, 7, sample width; the PWM period is 2^N ticks.
DIV, 1, clock cycles per PWM tick (DIV >= 1; DIV = 1 means one tick per clock).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable_i  input  1  run the PWM; deassertion finishes the current period, then stops
dacCount_i  input  N  sample value (duty)
sample_valid_i  input  1  dacCount_i is valid this cycle
sample_ready_o  output  1  shadow buffer empty; a sample is accepted when valid && ready
pwm_o  output  1  PWM output
period_start_o  output  1  one-cycle pulse after each duty load
underrun_o  output  1  one-cycle pulse when a duty load finds the shadow buffer empty

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; cnt=0; prescale=0; duty=0; shadow_full=0; shadow=0.
  - Outputs: pwm_o=0, sample_ready_o=1, period_start_o=0, underrun_o=0.
- Handshake:
  - sample_ready_o = ~shadow_full, taken from the register only (no combinational path from inputs).
  - On valid && ready: shadow <= dacCount_i, shadow_full <= 1.
  - Samples are accepted in every state, IDLE included.
- Tick: in RUN/FLUSH, prescale counts 0..DIV-1, and tick=1 when prescale==DIV-1. In IDLE, prescale is held at 0.
- Counter: on tick, cnt <= cnt+1, wrapping 2^N-1 -> 0 (N-bit natural wrap).
- pwm_o = (state != IDLE) && (cnt < duty), decoded from registers only.
  - Unsigned compare.
  - duty=0 gives constant low; duty=2^N-1 gives high for 2^N-1 of 2^N ticks.
- Load event occurs on two edges: (a) IDLE->RUN, and (b) tick with cnt==2^N-1 while in RUN.
  - If shadow_full: duty <= shadow, shadow_full <= 0.
  - Otherwise: duty keeps its previous value, and underrun_o pulses in the following cycle.
  - period_start_o pulses for one cycle in the cycle following every load event.
- A load event and a handshake never collide: ready=0 whenever shadow_full=1. If the shadow is empty at a load, that load underruns, and a sample arriving in the same cycle fills the shadow for the next period.
- FSM (enum in package):
  - IDLE: enable_i=1 -> RUN, with a load event and cnt=0.
  - RUN: enable_i=0 -> FLUSH. The counter keeps running, and no duty loads occur in FLUSH.
  - FLUSH:
    - enable_i=1 -> RUN, with no restart and the counter continuing.
    - Tick with cnt==2^N-1 -> IDLE, with cnt=0, prescale=0, pwm_o=0, and the shadow retained.
  - If enable_i returns high in FLUSH in the same cycle as the final wrap, the next state is RUN and that wrap is a normal load event.
- rst asserted mid-period: immediately returns to the reset values, and any buffered sample is discarded.

Decomposition:
- Package sound_pkg:
  - typedef enum DAC_STATE {IDLE, RUN, FLUSH}.
  - Default N and DIV constants.
- Sub-module tick_prescaler (params DIV; ports clk, rst, run, tick) generates the tick strobe. For DIV=1, tick=run.

Test Plan:
1. N=3, DIV=1: reset; send sample 3 while idle; raise enable -> period_start_o pulses once; pwm_o high for 3 cycles, then low for 5, repeating every 8 cycles; underrun_o pulses at each later boundary.
2. Duty update mid-period: running with duty 2, send sample 6 at cnt=4 -> waveform is unchanged until the wrap; the next period is high for 6 cycles; sample_ready_o stays 0 from acceptance until the load, then returns to 1.
3. Extremes: sample 0 -> pwm_o constantly 0 for a full period; sample 7 -> high for 7 cycles and low for 1.
4. Backpressure: shadow full, sample_valid_i held high with value 5 -> not accepted until the cycle after the load; exactly one 5 is taken per period.
5. Enable drop at cnt=2 with duty 4 -> the period completes (high until cnt=3, low to cnt=7), then IDLE with pwm_o=0. Re-enable during FLUSH at cnt=5 -> continuous waveform with no restart.
6. DIV=3, duty 1 -> pwm_o high for 3 clocks per 24-clock period. Assert rst at cnt=4 -> pwm_o=0 and sample_ready_o=1 immediately.
